btn_debounce_toggle: RTL and testbench

- Upstream conditioning stage for the push-button input of the display top level.
- Synchronises the raw KEY pin into the CLOCK_50 domain and debounces it with a 4-state FSM.
- Emits single-cycle press and release pulses, a press-toggled state (drives LEDG) and an 8-bit wrapping press count (feeds the HEX path).
- Replaces direct use of the raw toggleBtn level inside top_level.

---
 rtl/btn_debounce_toggle.sv | 167 ++++++++++++++++
 tb/tb_btn_debounce_toggle.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_toggle.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_toggle
// Purpose  : Synchronises and debounces the KEY push-button, producing press /
//            release pulses, a press-toggled level and a wrapping press count.
//            Optional long-press detector enabled by macro LONG_PRESS_EN.
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce_toggle #(
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       toggleBtn,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       toggle_q,
  output logic [7:0] press_count,
  output logic       long_pulse
);

  localparam logic                 c_IDLE_LEVEL = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_WIDTH) - 1 ||
      LONG_CYCLES < 1 || LONG_CYCLES > (2 ** 26)) begin : g_param_check
    $error("btn_debounce_toggle: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_sync1, r_sync2;
  logic                 w_pressed;
  logic                 w_press_evt, w_release_evt;

  // XOR with the idle level normalises the pin so that 1 always means pressed
  assign w_pressed = r_sync2 ^ c_IDLE_LEVEL;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= c_IDLE_LEVEL;
      r_sync2 <= c_IDLE_LEVEL;
    end else begin
      r_sync1 <= toggleBtn;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_evt   = 1'b0;
    w_release_evt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_pressed) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!w_pressed) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_press_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      PRESSED: begin
        if (!w_pressed) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (w_pressed) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = '0;
          w_release_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= RELEASED;
      r_cnt         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle_q      <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      press_pulse   <= w_press_evt;
      release_pulse <= w_release_evt;
      if (w_press_evt) begin
        btn_level   <= 1'b1;
        toggle_q    <= ~toggle_q;
        press_count <= press_count + 8'd1;
      end else if (w_release_evt) begin
        btn_level <= 1'b0;
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [25:0] c_LONG_LAST = 26'(LONG_CYCLES - 1);

  logic [25:0] r_hold;
  logic        r_long_done;

  // r_long_done is only cleared by a fresh accepted press, so a release bounce
  // back into PRESSED cannot produce a second long pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hold      <= 26'd0;
      r_long_done <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (w_press_evt) begin
        r_hold      <= 26'd0;
        r_long_done <= 1'b0;
      end else if (r_state == PRESSED && !r_long_done) begin
        if (r_hold == c_LONG_LAST) begin
          long_pulse  <= 1'b1;
          r_long_done <= 1'b1;
        end else begin
          r_hold <= r_hold + 26'd1;
        end
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_toggle.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_toggle
// Purpose  : Scoreboard bench for btn_debounce_toggle (DEBOUNCE_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_debounce_toggle;

  localparam int c_DEB  = 4;
  localparam int c_LONG = 10;
  localparam int c_LAT  = c_DEB + 3;  // drive at negedge N -> pulse seen at negedge N+7

  logic       clk = 1'b0;
  logic       reset;
  logic       toggleBtn;
  logic       btn_level, press_pulse, release_pulse, toggle_q, long_pulse;
  logic [7:0] press_count;

  btn_debounce_toggle #(
    .CNT_WIDTH      (20),
    .DEBOUNCE_CYCLES(c_DEB),
    .ACTIVE_LOW     (1),
    .LONG_CYCLES    (c_LONG)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .toggleBtn    (toggleBtn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .toggle_q     (toggle_q),
    .press_count  (press_count),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [2:0] kind;   // {long, release, press}
    int         at;
    logic       tq;
    logic [7:0] cnt;
    logic       lvl;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  logic       m_tq;
  logic [7:0] m_cnt;
  logic       m_lvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [2:0] kind, input int at);
    ev_t e;
    e.kind = kind; e.at = at; e.tq = m_tq; e.cnt = m_cnt; e.lvl = m_lvl;
    sb.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    if (press_pulse || release_pulse || long_pulse) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse: got kind=%b at cyc %0d expected none",
                 {long_pulse, release_pulse, press_pulse}, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if ({long_pulse, release_pulse, press_pulse} === e.kind && cyc == e.at &&
            toggle_q === e.tq && press_count === e.cnt && btn_level === e.lvl)
          n_pass++;
        else
          $display("FAIL event: got kind=%b cyc=%0d tq=%b cnt=%0d lvl=%b expected kind=%b cyc=%0d tq=%b cnt=%0d lvl=%b",
                   {long_pulse, release_pulse, press_pulse}, cyc, toggle_q, press_count,
                   btn_level, e.kind, e.at, e.tq, e.cnt, e.lvl);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_tq = 1'b0; m_cnt = 8'd0; m_lvl = 1'b0;
  endtask

  task automatic do_press(input int hold);
    toggleBtn = 1'b0;
    m_tq  = ~m_tq;
    m_cnt = m_cnt + 8'd1;
    m_lvl = 1'b1;
    push(3'b001, cyc + c_LAT);
`ifdef LONG_PRESS_EN
    if (hold >= 20) push(3'b100, cyc + c_LAT + c_LONG);
`endif
    wait_cyc(c_LAT + hold);
  endtask

  task automatic do_release(input int hold);
    toggleBtn = 1'b1;
    m_lvl = 1'b0;
    push(3'b010, cyc + c_LAT);
    wait_cyc(c_LAT + hold);
  endtask

  task automatic drive_for(input logic v, input int n);
    toggleBtn = v;
    wait_cyc(n);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_checks++;
    summary();
    $finish;
  end

  initial begin
    model_reset();
    reset = 1'b1;
    toggleBtn = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    // Idle with button released: every output stays low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs",
          {19'd0, btn_level, press_pulse, release_pulse, toggle_q, press_count, long_pulse}, 32'd0);
    end

    // Bounce: two 3-cycle lows are one short of the debounce window
    drive_for(1'b0, 3); drive_for(1'b1, 1);
    drive_for(1'b0, 3); drive_for(1'b1, 12);
    chk("bounce_level", {31'd0, btn_level}, 32'd0);
    chk("bounce_count", {24'd0, press_count}, 32'd0);

    // Clean press held long, then release
    do_press(30);
    chk("press_level", {31'd0, btn_level}, 32'd1);
    chk("press_toggle", {31'd0, toggle_q}, 32'd1);
    chk("press_count1", {24'd0, press_count}, 32'd1);
    do_release(3);
    chk("release_level", {31'd0, btn_level}, 32'd0);

    // Second press toggles back
    do_press(3);
    do_release(3);
    chk("toggle_second", {31'd0, toggle_q}, 32'd0);
    chk("count_second", {24'd0, press_count}, 32'd2);

    // Reset in WAIT_PRESS discards the pending press
    toggleBtn = 1'b0;
    wait_cyc(4);
    reset = 1'b1;
    toggleBtn = 1'b1;
    model_reset();
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(12);
    chk("rst_mid_count", {24'd0, press_count}, 32'd0);
    chk("rst_mid_toggle", {31'd0, toggle_q}, 32'd0);

    // Button held across reset release counts as a new press
    reset = 1'b1;
    toggleBtn = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    m_tq = 1'b1; m_cnt = 8'd1; m_lvl = 1'b1;
    push(3'b001, cyc + c_LAT);
    wait_cyc(c_LAT + 2);
    do_release(3);

    // 256 presses from a clean reset wrap the count to 0
    reset = 1'b1;
    model_reset();
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 256; i++) begin
      do_press(2);
      do_release(2);
    end
    chk("wrap_count", {24'd0, press_count}, 32'd0);
    chk("wrap_toggle", {31'd0, toggle_q}, 32'd0);

    wait_cyc(20);
    chk("scoreboard_drained", sb.size(), 32'd0);
    summary();
    $finish;
  end

endmodule
`default_nettype wire
